// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller state encoding and data width.
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        RXC_ARM,
        RXC_RELEASE,
        RXC_HOLD
    } rxc_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. The head reads as zero while empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign count  = r_count;
    assign head   = empty ? '0 : r_mem[r_rptr];

    // Storage array; contents are only observable through head when not empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: drives the receiver go/dr handshake on its own,
// buffers received bytes in a FWFT FIFO and flags frames lost while full.
`timescale 1ns/1ps
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    output logic                     urx_go,
    input  logic [UART_DATA_W-1:0]   urx_data,
    input  logic                     urx_dr,
    input  logic                     rd_en,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clr_ovr
);

    localparam int CW = $clog2(DEPTH) + 1;

    rxc_state_t    r_state;
    logic          r_go;
    logic          r_ovr;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_s3;
    logic          w_push;
    logic          w_pop;
    logic          w_rx_fall;
    logic [CW-1:0] w_cnt_after_pop;
    logic          w_full_after_pop;

    assign urx_go  = r_go;
    assign overrun = r_ovr;

    assign w_push    = (r_state == RXC_ARM) && urx_dr;
    assign w_pop     = rd_en && !empty;
    assign w_rx_fall = r_rx_s3 && !r_rx_s2;

    // No push can happen in RELEASE, so the post-update count only depends on the pop.
    assign w_cnt_after_pop  = w_pop ? (count - 1'b1) : count;
    assign w_full_after_pop = (w_cnt_after_pop == CW'(DEPTH));

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (urx_data),
        .pop       (rd_en),
        .head      (rd_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Handshake sequencer: arm, push on dr, wait for dr to drop, hold while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RXC_ARM;
            r_go    <= 1'b0;
        end else begin
            case (r_state)
                RXC_ARM: begin
                    if (urx_dr) begin
                        r_state <= RXC_RELEASE;
                        r_go    <= 1'b0;
                    end else begin
                        r_go    <= 1'b1;
                    end
                end
                RXC_RELEASE: begin
                    r_go <= 1'b0;
                    if (!urx_dr) begin
                        if (!w_full_after_pop) begin
                            r_state <= RXC_ARM;
                            r_go    <= 1'b1;
                        end else begin
                            r_state <= RXC_HOLD;
                        end
                    end
                end
                RXC_HOLD: begin
                    if (!full) begin
                        r_state <= RXC_ARM;
                        r_go    <= 1'b1;
                    end else begin
                        r_go    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RXC_ARM;
                    r_go    <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser on the serial line plus one stage for edge detect; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // Sticky overrun: a start bit while holding means a frame is lost; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if ((r_state == RXC_HOLD) && w_rx_fall) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: behavioural receiver, queue-based reference model,
// per-cycle output comparison and directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH    = 16;
    localparam int BIT_TIME = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   rx;
    logic                   urx_go;
    logic [7:0]             urx_data;
    logic                   urx_dr;
    logic                   rd_en;
    logic [7:0]             rd_data;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overrun;
    logic                   clr_ovr;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .urx_go   (urx_go),
        .urx_data (urx_data),
        .urx_dr   (urx_dr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, plus the rules for holding and overrun.
    byte unsigned mq[$];
    bit m_ovr, m_busy, m_hold, m_prev_dr;
    bit m_s1, m_s2, m_s3;

    always @(posedge clk or negedge rst_n) begin
        int  sz_pre;
        bit  fall;
        if (!rst_n) begin
            mq.delete();
            m_ovr = 0; m_busy = 0; m_hold = 0; m_prev_dr = 0;
            m_s1 = 1; m_s2 = 1; m_s3 = 1;
        end else begin
            sz_pre = mq.size();
            fall   = m_s3 && !m_s2;
            if (m_hold && fall) m_ovr = 1;
            else if (clr_ovr)   m_ovr = 0;
            if (rd_en && sz_pre > 0) void'(mq.pop_front());
            if (urx_dr && !m_prev_dr) begin
                mq.push_back(urx_data);
                m_busy = 1;
            end else if (m_busy && !urx_dr) begin
                m_busy = 0;
                if (mq.size() == DEPTH) m_hold = 1;
            end else if (m_hold && sz_pre < DEPTH) begin
                m_hold = 0;
            end
            m_prev_dr = urx_dr;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = rx;
        end
    end

    // Per-cycle comparison of every FIFO-facing output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_count",   32'(count),   32'(mq.size()));
            chk("cmp_empty",   32'(empty),   32'(mq.size() == 0));
            chk("cmp_full",    32'(full),    32'(mq.size() == DEPTH));
            chk("cmp_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    // Serial line waveform for one frame (start, 8 data LSB first, stop).
    task automatic send_bits(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT_TIME) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_TIME) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT_TIME) @(negedge clk);
    endtask

    // Receiver-side handshake: present the byte if armed; dr drops one cycle after go.
    task automatic deliver(input logic [7:0] b, input bit pop_too,
                           output logic [7:0] c1, output logic [7:0] d1);
        c1 = '0; d1 = '0;
        if (!urx_go) return;
        urx_data = b;
        urx_dr   = 1'b1;
        rd_en    = pop_too;
        @(negedge clk);
        rd_en = 1'b0;
        c1 = 8'(count);
        d1 = rd_data;
        for (int k = 0; k < 8 && urx_go; k++) @(negedge clk);
        chk("go_fall", 32'(urx_go), 32'd0);
        @(negedge clk);
        urx_dr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        logic [7:0] c1, d1;
        send_bits(b);
        deliver(b, 1'b0, c1, d1);
    endtask

    task automatic pop_one(output logic [7:0] d);
        d = rd_data;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d, c1, d1;
        logic [7:0] tx_q[$];
        logic [7:0] rx_q[$];

        rst_n = 1'b0; rx = 1'b1; urx_data = '0; urx_dr = 1'b0;
        rd_en = 1'b0; clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_go_after_reset", 32'(urx_go), 32'd1);

        // 1. Reset mid-frame with data held.
        send_frame(8'h11);
        send_frame(8'h22);
        chk("t1_count_pre", 32'(count), 32'd2);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_go",      32'(urx_go),  32'd0);
        chk("t1_rst_count",   32'(count),   32'd0);
        chk("t1_rst_empty",   32'(empty),   32'd1);
        chk("t1_rst_overrun", 32'(overrun), 32'd0);
        chk("t1_rst_rd_data", 32'(rd_data), 32'd0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_go_rearm", 32'(urx_go), 32'd1);

        // 2. Single byte.
        send_bits(8'hA5);
        deliver(8'hA5, 1'b0, c1, d1);
        chk("t2_count", 32'(c1), 32'd1);
        chk("t2_data",  32'(d1), 32'hA5);
        pop_one(d);
        chk("t2_pop_data", 32'(d),       32'hA5);
        chk("t2_empty",    32'(empty),   32'd1);
        chk("t2_rd_zero",  32'(rd_data), 32'd0);

        // 3. Fill, overrun on 17th start bit, drain in order.
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i));
        chk("t3_full", 32'(full),   32'd1);
        chk("t3_go",   32'(urx_go), 32'd0);
        send_bits(8'h10);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_count16", 32'(count),   32'd16);
        chk("t3_go_still0", 32'(urx_go), 32'd0);
        pop_one(d);
        chk("t3_drain0", 32'(d), 32'd0);
        for (int k = 0; k < 3 && !urx_go; k++) @(negedge clk);
        chk("t3_go_after_pop", 32'(urx_go), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            pop_one(d);
            chk("t3_drain", 32'(d), 32'(i));
        end
        chk("t3_empty", 32'(empty), 32'd1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4. Wrap: 40 bytes, pops keep occupancy at most 3.
        for (int i = 0; i < 40; i++) begin
            d1 = 8'((i * 37 + 5) & 8'hFF);
            tx_q.push_back(d1);
            send_frame(d1);
            if (count >= 3) begin
                pop_one(d);
                rx_q.push_back(d);
            end
        end
        for (int k = 0; k < DEPTH + 2 && !empty; k++) begin
            pop_one(d);
            rx_q.push_back(d);
        end
        chk("t4_len", 32'(rx_q.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx_q.size(); i++) chk("t4_seq", 32'(rx_q[i]), 32'(tx_q[i]));

        // 5. Simultaneous push + pop at count 5, then set-vs-clear on overrun.
        for (int i = 0; i < 5; i++) send_frame(8'(8'h50 + i));
        send_bits(8'h55);
        deliver(8'h55, 1'b1, c1, d1);
        chk("t5_count5", 32'(c1), 32'd5);
        chk("t5_head",   32'(d1), 32'h51);
        for (int i = 1; i < 6; i++) begin
            pop_one(d);
            chk("t5_drain", 32'(d), 32'(8'h50 + i));
        end
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'hC0 + i));
        chk("t5_full", 32'(full), 32'd1);
        rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t5_set_wins", 32'(overrun), 32'd1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t5_cleared", 32'(overrun), 32'd0);
        for (int k = 0; k < DEPTH + 2 && !empty; k++) pop_one(d);
        repeat (3) @(negedge clk);

        // 6. Pops on an empty FIFO are ignored.
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        chk("t6_count",   32'(count),   32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        chk("t6_go",      32'(urx_go),  32'd1);
        send_frame(8'h3C);
        chk("t6_after_count", 32'(count),   32'd1);
        chk("t6_after_data",  32'(rd_data), 32'h3C);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
